// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: op codes, handshake FSM states, compare flags.
package alu_pkg;

    localparam int XLEN_DEF = 64;
    localparam int CNT_W    = $clog2(XLEN_DEF);

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_AND   = 4'd2,
        OP_OR    = 4'd3,
        OP_XOR   = 4'd4,
        OP_SLL   = 4'd5,
        OP_SRL   = 4'd6,
        OP_SRA   = 4'd7,
        OP_SLT   = 4'd8,
        OP_SLTU  = 4'd9,
        OP_MUL   = 4'd10,
        OP_MULHU = 4'd11,
        OP_DIVU  = 4'd12,
        OP_REMU  = 4'd13,
        OP_RSV14 = 4'd14,
        OP_RSV15 = 4'd15
    } alu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } alu_state_e;

    typedef struct packed {
        logic eq;
        logic ne;
        logic lt;
        logic ge;
        logic ult;
        logic uge;
    } alu_flags_t;

    function automatic logic is_muldiv(input alu_op_e op);
        return (op == OP_MUL) || (op == OP_MULHU) || (op == OP_DIVU) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned multiplier (shift-add) and restoring divider, one bit per cycle.
// res_o carries the post-iteration value so the caller can register it on the done_o cycle.
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic            div_i,
    input  logic            hi_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            done_o,
    output logic [XLEN-1:0] res_o
);
    localparam int CW = $clog2(XLEN);

    logic              active_q, div_q, hi_q;
    logic [CW-1:0]     cnt_q;
    logic [2*XLEN-1:0] prod_q, prod_d;
    logic [XLEN-1:0]   opb_q, quo_q, quo_d;
    logic [XLEN:0]     rem_q, rem_d;
    logic [XLEN:0]     mul_sum;
    logic [XLEN+1:0]   shifted, trial;

    always_comb begin
        mul_sum = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, opb_q} : '0);
        prod_d  = {mul_sum, prod_q[XLEN-1:1]};

        // Trial subtract one bit wider than the remainder so its sign is the borrow.
        shifted = {rem_q, quo_q[XLEN-1]};
        trial   = shifted - {2'b00, opb_q};
        if (trial[XLEN+1]) begin
            rem_d = shifted[XLEN:0];
            quo_d = {quo_q[XLEN-2:0], 1'b0};
        end else begin
            rem_d = trial[XLEN:0];
            quo_d = {quo_q[XLEN-2:0], 1'b1};
        end

        if (div_q) res_o = hi_q ? rem_d[XLEN-1:0] : quo_d;
        else       res_o = hi_q ? prod_d[2*XLEN-1:XLEN] : prod_d[XLEN-1:0];
    end

    assign done_o = active_q && (cnt_q == CW'(XLEN - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            div_q    <= 1'b0;
            hi_q     <= 1'b0;
            cnt_q    <= '0;
            prod_q   <= '0;
            opb_q    <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
        end else if (start_i) begin
            active_q <= 1'b1;
            div_q    <= div_i;
            hi_q     <= hi_i;
            cnt_q    <= '0;
            prod_q   <= {{XLEN{1'b0}}, a_i};
            opb_q    <= b_i;
            quo_q    <= a_i;
            rem_q    <= '0;
        end else if (active_q) begin
            cnt_q <= cnt_q + CW'(1);
            if (done_o) active_q <= 1'b0;
            if (div_q) begin
                rem_q <= rem_d;
                quo_q <= quo_d;
            end else begin
                prod_q <= prod_d;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle arith/logic/shift/compare ops plus iterative MUL/MULHU/DIVU/REMU.
// Result and compare flags are latched at acceptance and held until out_ready.
module alu_seq
    import alu_pkg::*;
#(
    parameter int XLEN      = XLEN_DEF,
    parameter int MULDIV_EN = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [3:0]      op,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            equal,
    output logic            not_equal,
    output logic            lesser_than,
    output logic            greater_or_equal,
    output logic            unsigned_lesser,
    output logic            unsigned_greater_equal,
    output logic            busy
);
    localparam int SH_W = $clog2(XLEN);

    alu_state_e      state_q;
    alu_flags_t      flags_q, flags_d;
    alu_op_e         op_e;
    logic [XLEN-1:0] result_q, alu_res_d, md_res;
    logic [XLEN:0]   sdiff, udiff;
    logic [SH_W-1:0] shamt;
    logic            md_op, md_div, md_hi, md_start, md_done;

    assign op_e     = alu_op_e'(op);
    assign shamt    = b[SH_W-1:0];
    assign md_op    = (MULDIV_EN != 0) && is_muldiv(op_e);
    assign md_div   = (op_e == OP_DIVU) || (op_e == OP_REMU);
    assign md_hi    = (op_e == OP_MULHU) || (op_e == OP_REMU);
    assign md_start = in_valid && (state_q == S_IDLE) && md_op;

    // Sign-extended difference keeps the true sign even when a-b overflows XLEN bits.
    assign sdiff = {a[XLEN-1], a} - {b[XLEN-1], b};
    assign udiff = {1'b0, a} - {1'b0, b};

    always_comb begin
        flags_d.eq  = (a == b);
        flags_d.ne  = ~flags_d.eq;
        flags_d.lt  = sdiff[XLEN];
        flags_d.ge  = ~flags_d.lt;
        flags_d.ult = udiff[XLEN];
        flags_d.uge = ~flags_d.ult;

        alu_res_d = '0;
        case (op_e)
            OP_ADD:  alu_res_d = a + b;
            OP_SUB:  alu_res_d = a - b;
            OP_AND:  alu_res_d = a & b;
            OP_OR:   alu_res_d = a | b;
            OP_XOR:  alu_res_d = a ^ b;
            OP_SLL:  alu_res_d = a << shamt;
            OP_SRL:  alu_res_d = a >> shamt;
            OP_SRA:  alu_res_d = $unsigned($signed(a) >>> shamt);
            OP_SLT:  alu_res_d = {{(XLEN-1){1'b0}}, sdiff[XLEN]};
            OP_SLTU: alu_res_d = {{(XLEN-1){1'b0}}, udiff[XLEN]};
            default: alu_res_d = '0;
        endcase
    end

    if (MULDIV_EN != 0) begin : g_md
        alu_muldiv_iter #(.XLEN(XLEN)) u_iter (
            .clk     (clk),
            .rst_n   (rst_n),
            .start_i (md_start),
            .div_i   (md_div),
            .hi_i    (md_hi),
            .a_i     (a),
            .b_i     (b),
            .done_o  (md_done),
            .res_o   (md_res)
        );
    end else begin : g_no_md
        assign md_done = 1'b0;
        assign md_res  = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (in_valid) begin
                    flags_q <= flags_d;
                    if (md_op) begin
                        state_q <= md_div ? S_DIV : S_MUL;
                    end else begin
                        result_q <= alu_res_d;
                        state_q  <= S_DONE;
                    end
                end
                S_MUL, S_DIV: if (md_done) begin
                    result_q <= md_res;
                    state_q  <= S_DONE;
                end
                S_DONE: if (out_ready) state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready               = (state_q == S_IDLE);
    assign busy                   = (state_q != S_IDLE);
    assign out_valid              = (state_q == S_DONE);
    assign result                 = result_q;
    assign equal                  = flags_q.eq;
    assign not_equal              = flags_q.ne;
    assign lesser_than            = flags_q.lt;
    assign greater_or_equal       = flags_q.ge;
    assign unsigned_lesser        = flags_q.ult;
    assign unsigned_greater_equal = flags_q.uge;

endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq at XLEN=64 with hand-computed results, flags and latencies.
module tb_alu_seq;

    logic        clk, rst_n, in_valid, in_ready, out_valid, out_ready, busy;
    logic [63:0] a, b, result;
    logic [3:0]  op;
    logic        equal, not_equal, lesser_than, greater_or_equal;
    logic        unsigned_lesser, unsigned_greater_equal;

    int checks = 0;
    int errors = 0;

    alu_seq #(.XLEN(64), .MULDIV_EN(1)) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .in_valid               (in_valid),
        .in_ready               (in_ready),
        .a                      (a),
        .b                      (b),
        .op                     (op),
        .out_valid              (out_valid),
        .out_ready              (out_ready),
        .result                 (result),
        .equal                  (equal),
        .not_equal              (not_equal),
        .lesser_than            (lesser_than),
        .greater_or_equal       (greater_or_equal),
        .unsigned_lesser        (unsigned_lesser),
        .unsigned_greater_equal (unsigned_greater_equal),
        .busy                   (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [3:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] res;
        logic [5:0]  fl;   // {eq, ne, lt, ge, ult, uge}
        int          lat;  // clock edges from acceptance to out_valid
    } vec_t;

    localparam int NV = 25;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic [3:0] o, input logic [63:0] va, input logic [63:0] vb,
                                input logic [63:0] r, input logic [5:0] f, input int l);
        vec_t v;
        v.op = o; v.a = va; v.b = vb; v.res = r; v.fl = f; v.lat = l;
        return v;
    endfunction

    function automatic logic [5:0] flags_now();
        return {equal, not_equal, lesser_than, greater_or_equal, unsigned_lesser, unsigned_greater_equal};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Entered #1 after an edge with the DUT idle; leaves it idle again.
    task automatic run_vec(input vec_t v, input string nm);
        int lat;
        op = v.op; a = v.a; b = v.b; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = ~v.a; b = v.b ^ 64'h5555_5555_5555_5555; op = 4'd15;
        chk({nm, " busy"}, 64'(busy), 64'd1);
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({nm, " latency"}, 64'(lat), 64'(v.lat));
        chk({nm, " result"}, result, v.res);
        chk({nm, " flags"}, 64'(flags_now()), 64'(v.fl));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({nm, " idle"}, {62'd0, in_ready, out_valid}, 64'b10);
    endtask

    initial begin
        int cnt;
        logic seen;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = '0;

        vecs[0]  = mk(4'd1,  64'd5, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 6'b011010, 0);
        vecs[1]  = mk(4'd1,  64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 6'b011001, 0);
        vecs[2]  = mk(4'd0,  64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 6'b011001, 0);
        vecs[3]  = mk(4'd2,  64'hF0F0_F0F0_F0F0_F0F0, 64'h0FF0_0FF0_0FF0_0FF0, 64'h00F0_00F0_00F0_00F0, 6'b011001, 0);
        vecs[4]  = mk(4'd3,  64'hF0F0_F0F0_F0F0_F0F0, 64'h0FF0_0FF0_0FF0_0FF0, 64'hFFF0_FFF0_FFF0_FFF0, 6'b011001, 0);
        vecs[5]  = mk(4'd4,  64'hF0F0_F0F0_F0F0_F0F0, 64'h0FF0_0FF0_0FF0_0FF0, 64'hFF00_FF00_FF00_FF00, 6'b011001, 0);
        vecs[6]  = mk(4'd5,  64'd1, 64'h13F, 64'h8000_0000_0000_0000, 6'b011010, 0);
        vecs[7]  = mk(4'd6,  64'h8000_0000_0000_0000, 64'd4, 64'h0800_0000_0000_0000, 6'b011001, 0);
        vecs[8]  = mk(4'd7,  64'h8000_0000_0000_0000, 64'd4, 64'hF800_0000_0000_0000, 6'b011001, 0);
        vecs[9]  = mk(4'd8,  64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1, 6'b011001, 0);
        vecs[10] = mk(4'd9,  64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 6'b011001, 0);
        vecs[11] = mk(4'd0,  64'd3, 64'd3, 64'd6, 6'b100101, 0);
        vecs[12] = mk(4'd14, 64'd5, 64'd2, 64'd0, 6'b010101, 0);
        vecs[13] = mk(4'd1,  64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 6'b010110, 0);
        vecs[14] = mk(4'd11, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 6'b100101, 64);
        vecs[15] = mk(4'd10, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 6'b100101, 64);
        vecs[16] = mk(4'd12, 64'd100, 64'd7, 64'd14, 6'b010101, 64);
        vecs[17] = mk(4'd13, 64'd100, 64'd7, 64'd2, 6'b010101, 64);
        vecs[18] = mk(4'd12, 64'd12345, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 6'b010101, 64);
        vecs[19] = mk(4'd13, 64'd9, 64'd0, 64'd9, 6'b010101, 64);
        vecs[20] = mk(4'd10, 64'h1_0000_0001, 64'h1_0000_0003, 64'h0000_0004_0000_0003, 6'b011010, 64);
        vecs[21] = mk(4'd11, 64'h1_0000_0001, 64'h1_0000_0003, 64'd1, 6'b011010, 64);
        vecs[22] = mk(4'd12, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'h7FFF_FFFF_FFFF_FFFF, 6'b011001, 64);
        vecs[23] = mk(4'd13, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd1, 6'b011001, 64);
        vecs[24] = mk(4'd15, 64'd7, 64'd9, 64'd0, 6'b011010, 0);

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("reset in_ready", 64'(in_ready), 64'd1);
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset result", result, 64'd0);
        chk("reset flags", 64'(flags_now()), 64'd0);
        @(posedge clk); #1;

        for (int i = 0; i < NV; i++) run_vec(vecs[i], $sformatf("v%0d", i));

        // Backpressure: result held, new requests ignored while out_ready is low.
        op = 4'd0; a = 64'd3; b = 64'd4; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        op = 4'd1; a = 64'd1; b = 64'd1;
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("bp%0d valid", i), 64'(out_valid), 64'd1);
            chk($sformatf("bp%0d result", i), result, 64'd7);
            chk($sformatf("bp%0d in_ready", i), 64'(in_ready), 64'd0);
            @(posedge clk); #1;
        end
        chk("bp flags", 64'(flags_now()), 64'(6'b011010));
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp release", {62'd0, in_ready, out_valid}, 64'b10);

        // Back-to-back throughput with both sides always ready: one result per two cycles.
        op = 4'd0; a = 64'd3; b = 64'd4; in_valid = 1'b1; out_ready = 1'b1;
        cnt = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (out_valid) cnt++;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        chk("throughput", 64'(cnt), 64'd5);
        chk("throughput idle", 64'(in_ready), 64'd1);

        // Reset mid-divide aborts the op with no result.
        op = 4'd12; a = 64'd100; b = 64'd7; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("abort busy before", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("abort out_valid", 64'(out_valid), 64'd0);
        chk("abort busy", 64'(busy), 64'd0);
        chk("abort result", result, 64'd0);
        chk("abort flags", 64'(flags_now()), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (70) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        chk("abort no stray result", 64'(seen), 64'd0);
        run_vec(mk(4'd0, 64'd3, 64'd4, 64'd7, 6'b011010, 0), "post-abort add");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
